// File: rtl/mpc_types.sv
// Shared types for the banked reorder buffer return path.
package mpc_types;
    localparam int ROB_NUM_BANKS = 4;
    typedef logic [$clog2(ROB_NUM_BANKS)-1:0] rob_bank_id_t;
endpackage

// File: rtl/rob_rr_arb.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping.
// Zero latency; no state, the caller owns the pointer and any backpressure.
module rob_rr_arb #(
    parameter  int N   = 4,
    localparam int IdW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IdW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IdW-1:0] idx,
    output logic           any
);

    logic [IdW-1:0] cand;

    // N is a power of two, so IdW-bit addition wraps modulo N for free
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + IdW'(k);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_bank_sched.sv
// Round-robin merge of ROB bank read-out channels into one registered upstream channel, plus credit serialiser.
// One-cycle data and credit latency; full throughput; bank ready is withheld while the output register is stalled.
module rob_bank_sched
    import mpc_types::*;
#(
    parameter  int NumBanks     = ROB_NUM_BANKS,
    parameter  int DataWidth    = 128,
    parameter  int CrdtCntWidth = 4,
    localparam int IdW          = $clog2(NumBanks)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NumBanks-1:0]           d_ch_valid,
    output logic [NumBanks-1:0]           d_ch_ready,
    input  logic [NumBanks*DataWidth-1:0] d_ch_data,
    input  logic [NumBanks-1:0]           d_isu_crdt_rtn,
    output logic                          u_ch_valid,
    input  logic                          u_ch_ready,
    output logic [DataWidth-1:0]          u_ch_data,
    output logic [IdW-1:0]                u_ch_bank_id,
    output logic                          u_xbar_crdt_rtn
);

    localparam int AccW = CrdtCntWidth + 1;

    logic [IdW-1:0]       ptr;
    logic [IdW-1:0]       gnt_idx;
    logic [NumBanks-1:0]  gnt;
    logic                 gnt_any;
    logic                 accept;
    logic [DataWidth-1:0] sel_data;

    rob_rr_arb #(.N(NumBanks)) u_arb (
        .req   (d_ch_valid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign accept     = !u_ch_valid || u_ch_ready;
    assign d_ch_ready = (rst_n && accept) ? gnt : '0;
    assign sel_data   = d_ch_data[int'(gnt_idx)*DataWidth +: DataWidth];

    // Data and id only move on a transfer, so they stay stable under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_ch_valid   <= 1'b0;
            u_ch_data    <= '0;
            u_ch_bank_id <= '0;
            ptr          <= '0;
        end else if (accept) begin
            u_ch_valid <= gnt_any;
            if (gnt_any) begin
                u_ch_data    <= sel_data;
                u_ch_bank_id <= gnt_idx;
                ptr          <= gnt_idx + IdW'(1);
            end
        end
    end

    logic [CrdtCntWidth-1:0] cnt;
    logic [AccW-1:0]         inc;
    logic [AccW-1:0]         avail;
    logic                    avail_nz;

    always_comb begin
        inc = '0;
        for (int b = 0; b < NumBanks; b++) begin
            inc = inc + AccW'(d_isu_crdt_rtn[b]);
        end
    end

    assign avail    = {1'b0, cnt} + inc;
    assign avail_nz = |avail;

    // Dropping the top bit before the decrement is exact whenever avail-1 fits in cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            u_xbar_crdt_rtn <= 1'b0;
        end else begin
            cnt             <= avail[CrdtCntWidth-1:0] - CrdtCntWidth'(avail_nz);
            u_xbar_crdt_rtn <= avail_nz;
        end
    end

endmodule

// File: tb/tb_rob_bank_sched.sv
// Randomised and directed bench for rob_bank_sched with a queue-based reference model and scoreboard.
module tb_rob_bank_sched;
    localparam int NB = 4;
    localparam int DW = 128;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NB-1:0]     d_ch_valid;
    logic [NB-1:0]     d_ch_ready;
    logic [NB*DW-1:0]  d_ch_data;
    logic [NB-1:0]     d_isu_crdt_rtn;
    logic              u_ch_valid;
    logic              u_ch_ready;
    logic [DW-1:0]     u_ch_data;
    logic [1:0]        u_ch_bank_id;
    logic              u_xbar_crdt_rtn;

    always #5 clk = ~clk;

    rob_bank_sched #(.NumBanks(NB), .DataWidth(DW), .CrdtCntWidth(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .d_ch_valid      (d_ch_valid),
        .d_ch_ready      (d_ch_ready),
        .d_ch_data       (d_ch_data),
        .d_isu_crdt_rtn  (d_isu_crdt_rtn),
        .u_ch_valid      (u_ch_valid),
        .u_ch_ready      (u_ch_ready),
        .u_ch_data       (u_ch_data),
        .u_ch_bank_id    (u_ch_bank_id),
        .u_xbar_crdt_rtn (u_xbar_crdt_rtn)
    );

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] dat;
    } beat_t;

    int            n_chk = 0;
    int            n_fail = 0;
    beat_t         sb[$];
    logic [DW-1:0] bq[NB][$];
    int            seen[$];

    logic [NB-1:0] en;
    logic          rdy;
    logic [NB-1:0] crd;

    // Reference model: output-register occupancy, rr pointer, pending credits
    bit m_uv;
    bit m_crdt;
    int m_ptr;
    int m_pend;

    logic [DW-1:0] a5;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_uv = 0;
        m_crdt = 0;
        m_ptr = 0;
        m_pend = 0;
        sb.delete();
    endtask

    task automatic push_beat(input int b, input logic [DW-1:0] v);
        bq[b].push_back(v);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: check registered outputs, drive inputs, check ready, advance model
    task automatic step();
        logic [NB-1:0] v;
        logic [NB-1:0] g;
        int            gi;
        int            inc;
        bit            acc;
        @(posedge clk);
        #1;
        chk("u_ch_valid", u_ch_valid, m_uv);
        chk("u_xbar_crdt_rtn", u_xbar_crdt_rtn, m_crdt);
        for (int b = 0; b < NB; b++) begin
            v[b] = en[b] && (bq[b].size() > 0);
            d_ch_data[b*DW +: DW] = v[b] ? bq[b][0] : '0;
        end
        d_ch_valid = v;
        u_ch_ready = rdy;
        d_isu_crdt_rtn = crd;
        #1;
        acc = !m_uv || rdy;
        gi = -1;
        for (int k = 0; k < NB; k++) begin
            if (gi < 0 && v[(m_ptr + k) % NB]) gi = (m_ptr + k) % NB;
        end
        g = '0;
        if (acc && gi >= 0) g[gi] = 1'b1;
        chk("d_ch_ready", d_ch_ready, g);
        if (g != 0) begin
            sb.push_back({2'(gi), bq[gi].pop_front()});
            m_ptr = (gi + 1) % NB;
            m_uv = 1;
        end else if (acc) begin
            m_uv = 0;
        end
        inc = $countones(crd);
        chk("crdt_overflow", ((m_pend + inc - 1) > (2**CW - 1)) ? 1 : 0, 0);
        m_crdt = (m_pend + inc) > 0;
        m_pend = m_pend + inc - (m_crdt ? 1 : 0);
    endtask

    task automatic drain(input int budget);
        int left;
        left = budget;
        en = '1;
        rdy = 1'b1;
        crd = '0;
        while (left > 0 && (sb.size() > 0 || m_uv || m_pend > 0 ||
                            bq[0].size() + bq[1].size() + bq[2].size() + bq[3].size() > 0)) begin
            step();
            left--;
        end
        chk("drain_budget", (left > 0) ? 1 : 0, 1);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && u_ch_valid && u_ch_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got bank %0d with no expected beat", u_ch_bank_id);
            end else begin
                e = sb.pop_front();
                chk("u_ch_bank_id", u_ch_bank_id, e.id);
                chk("u_ch_data", u_ch_data, e.dat);
                seen.push_back(int'(u_ch_bank_id));
            end
        end
    end

    initial begin
        int errs;
        a5 = {16{8'hA5}};
        en = '0;
        rdy = 1'b1;
        crd = '0;
        d_ch_valid = '0;
        d_ch_data = '0;
        d_isu_crdt_rtn = '0;
        u_ch_ready = 1'b1;
        model_reset();

        // Reset with every bank presenting a beat
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < 6; i++) push_beat(b, rnd_data());
        d_ch_valid = '1;
        d_ch_data = {NB{a5}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_u_ch_valid", u_ch_valid, 0);
        chk("rst_u_ch_data", u_ch_data, 0);
        chk("rst_u_ch_bank_id", u_ch_bank_id, 0);
        chk("rst_crdt", u_xbar_crdt_rtn, 0);
        chk("rst_d_ch_ready", d_ch_ready, 0);
        d_ch_valid = '0;
        #1 rst_n = 1'b1;

        // All banks valid: strict rotation, one beat per cycle
        en = '1;
        seen.delete();
        step();
        chk("first_grant", d_ch_ready, 4'b0001);
        repeat (25) step();
        chk("fair_cnt", seen.size(), 24);
        errs = 0;
        foreach (seen[i]) if (seen[i] != i % NB) errs++;
        chk("fair_seq_errs", errs, 0);

        // Only banks 1 and 3
        en = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            push_beat(1, rnd_data());
            push_beat(3, rnd_data());
        end
        seen.delete();
        repeat (10) step();
        errs = 0;
        foreach (seen[i]) if (seen[i] != ((i % 2 == 0) ? 1 : 3)) errs++;
        chk("alt_cnt", seen.size(), 8);
        chk("alt_seq_errs", errs, 0);

        // Backpressure on a beat from bank 2
        en = '1;
        push_beat(2, a5);
        push_beat(2, rnd_data());
        push_beat(3, rnd_data());
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data", u_ch_data, a5);
            chk("bp_id", u_ch_bank_id, 2);
            chk("bp_ready", d_ch_ready, 0);
        end
        rdy = 1'b1;
        step();
        chk("bp_release_grant", d_ch_ready, 4'b1000);
        drain(40);

        // Single beat bubble from bank 1
        en = 4'b0010;
        repeat (2) step();
        push_beat(1, rnd_data());
        step();
        chk("bubble_accept_cycle", u_ch_valid, 0);
        step();
        chk("bubble_next_cycle", u_ch_valid, 1);
        step();
        chk("bubble_consumed", u_ch_valid, 0);

        // Credit burst of four
        crd = 4'b1111;
        step();
        crd = '0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("burst_pulse", u_xbar_crdt_rtn, (i <= 4) ? 1 : 0);
        end
        chk("burst_cnt_final", dut.cnt, 0);

        // Overlapping credit returns
        crd = 4'b0011;
        step();
        crd = 4'b0100;
        step();
        chk("overlap_pulse1", u_xbar_crdt_rtn, 1);
        crd = '0;
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("overlap_pulse", u_xbar_crdt_rtn, (i <= 3) ? 1 : 0);
        end

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            en = NB'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < NB; b++) begin
                crd[b] = ($urandom_range(0, 7) == 0);
                if (bq[b].size() < 3 && $urandom_range(0, 1) == 1) push_beat(b, rnd_data());
            end
            step();
        end
        drain(200);

        // Reset with a stalled beat and pending credits in flight
        push_beat(0, rnd_data());
        push_beat(0, rnd_data());
        en = '1;
        rdy = 1'b0;
        crd = 4'b1111;
        step();
        crd = '0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_u_ch_valid", u_ch_valid, 0);
        chk("midrst_crdt", u_xbar_crdt_rtn, 0);
        chk("midrst_d_ch_ready", d_ch_ready, 0);
        chk("midrst_cnt", dut.cnt, 0);
        model_reset();
        for (int b = 0; b < NB; b++) bq[b].delete();
        d_ch_valid = '0;
        d_isu_crdt_rtn = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy = 1'b1;
        repeat (3) step();

        chk("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rob_bank_sched.md
# rob_bank_sched

Scheduler for the banked reorder buffer on the xbar return path. It round-robin arbitrates the per-bank ROB read-out channels onto the single upstream response channel through a registered, full-throughput output stage. It also serialises the per-bank issue-credit returns into the single-bit credit pulse the xbar expects. It sits between the ROB banks and the upstream channel/xbar, replacing direct OR-ing of bank valids and credits.

## Interface
Parameters:
- `NumBanks`, 4, number of ROB banks; power of two, ≥2
- `DataWidth`, 128, response data width
- `CrdtCntWidth`, 4, width of pending-credit accumulator; must hold the maximum number of outstanding unreturned credits

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `d_ch_valid`  in  NumBanks  per-bank response valid
- `d_ch_ready`  out  NumBanks  per-bank response ready (grant & accept)
- `d_ch_data`  in  NumBanks×DataWidth  per-bank response data
- `d_isu_crdt_rtn`  in  NumBanks  per-bank credit-return pulse, one credit per cycle-high
- `u_ch_valid`  out  1  upstream response valid (registered)
- `u_ch_ready`  in  1  upstream ready
- `u_ch_data`  out  DataWidth  upstream data (registered)
- `u_ch_bank_id`  out  $clog2(NumBanks)  source bank of current `u_ch_data`
- `u_xbar_crdt_rtn`  out  1  credit-return pulse to xbar (registered)

## Operation
- Output stage: single register {valid, bank_id, data}. `accept = !u_ch_valid | u_ch_ready`.
- Arbitration: round-robin pointer `ptr`. Grant goes to the first bank i with `d_ch_valid[i]`, scanning ptr, ptr+1, … modulo NumBanks. Exactly one grant or none.
- `d_ch_ready[i] = accept & grant[i]`; at most one bit high per cycle. `d_ch_ready` depends combinationally on valids/`u_ch_ready`, so banks must not make valid depend on ready.
- On transfer (accept & any valid): the register loads the granted bank's data/id, `u_ch_valid` becomes 1, and `ptr` becomes granted+1 mod NumBanks (wrap from NumBanks-1 to 0).
- If accept is high and no bank is valid: `u_ch_valid` becomes 0 and `ptr` holds.
- If accept is low: the register and `ptr` hold. `u_ch_data`/`u_ch_bank_id` are stable while `u_ch_valid & !u_ch_ready`.
- Credit accumulator `cnt`:
  - `inc = popcount(d_isu_crdt_rtn)`, range 0..NumBanks.
  - `avail = cnt + inc`, computed at CrdtCntWidth+1 bits.
  - Next `u_xbar_crdt_rtn` = (avail != 0).
  - Next `cnt` = avail − (avail != 0).
  - Net effect: one credit is drained per cycle; simultaneous returns are queued, never dropped.
- Overflow (`avail − 1` > 2^CrdtCntWidth − 1) is illegal. The bench asserts it never happens; RTL behaviour on overflow is undefined.

## Timing
- Reset values: `u_ch_valid`=0, `u_ch_data`=0, `u_ch_bank_id`=0, `u_xbar_crdt_rtn`=0, `ptr`=0, `cnt`=0. `d_ch_ready` is combinational and 0 while `rst_n` is low.
- Data latency: bank beat accepted in cycle N appears on `u_ch_*` in cycle N+1.
- Throughput: one beat per cycle sustained while `u_ch_ready`=1.
- Credit latency: a lone credit pulse in cycle N gives `u_xbar_crdt_rtn`=1 in cycle N+1. k simultaneous credits give k consecutive pulses starting at N+1.
- Reset mid-operation: the in-flight output beat and pending credits are discarded.

## Structure
- `mpc_types` gains `rob_bank_id_t` (logic [$clog2(NumBanks)-1:0]) and constant `ROB_NUM_BANKS = 4`.
- One sub-module, `rob_rr_arb`: a parameterised combinational round-robin grant from {req, ptr}, outputting a one-hot grant and its encoded index. Pointer update stays in `rob_bank_sched`.
- Popcount and accumulator are inline.

## Test plan
- Reset: hold `rst_n`=0 with all banks valid → all outputs 0, `d_ch_ready`=0. Release → first grant goes to bank 0 (ptr=0).
- Fairness:
  - all 4 banks continuously valid, `u_ch_ready`=1 → `u_ch_bank_id` sequence 0,1,2,3,0,1… one beat per cycle
  - only banks 1 and 3 valid → 1,3,1,3
- Backpressure: `u_ch_ready`=0 for 5 cycles with data 0xA5…A5 held from bank 2 → `u_ch_data`/`u_ch_bank_id` stable, all `d_ch_ready`=0. Ready rises → next bank (3) is granted the same cycle.
- Bubble: single beat from bank 1 then no valids → `u_ch_valid` high exactly 1 cycle after accept, drops to 0 once consumed.
- Credit burst: `d_isu_crdt_rtn`=4'b1111 in cycle N, then 0 → `u_xbar_crdt_rtn` high in cycles N+1..N+4, low at N+5, `cnt` ends at 0.
- Credit overlap: 4'b0011 in cycle N and 4'b0100 in cycle N+1 → exactly 3 consecutive pulses from N+1; the overflow assertion never fires.
